rv32_regfile_alu: RTL and testbench
===================================

Name: rv32_regfile_alu

Overview:
- Integer execution slice for a multi-cycle RV32I core.
- Contains a 32x32 register file (x0 hardwired to zero, two combinational read ports, one synchronous write port).
- Contains an ALU-control decoder that maps funct3/funct7/instruction-format code to a 4-bit ALU operation.
- Contains a combinational 32-bit ALU with a zero flag. The core FSM drives operands, selects and write-back.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  reset, synchronous, active-low
- rs1  input  5  read address, port 1
- rs2  input  5  read address, port 2
- rd  input  5  write address
- wdata  input  32  write data
- we  input  1  register write enable
- rdata1  output  32  regs[rs1]
- rdata2  output  32  regs[rs2]
- funct3  input  3  instruction funct3
- funct7  input  7  instruction funct7
- fmt  input  4  format code: 0 R, 1 I, 2 IL(load), 3 IE(env), 4 S, 5 B, 6 J(jal), 7 JI(jalr), 8 U(lui), 9 UP(auipc)
- alu_a  input  32  ALU operand A
- alu_b  input  32  ALU operand B
- alu_ctr  output  4  decoded ALU operation, exported for debug
- alu_result  output  32  ALU result
- zero  output  1  1 when alu_result == 0

Behaviour:
- Clock and reset: clk, rising edge. resetn is synchronous, active-low: on a rising edge with resetn=0, all 32 registers are cleared to 0 and any write is suppressed.
- Register file writes: on a rising edge with resetn=1, we=1 and rd!=0, regs[rd] <= wdata. Writes to x0 are ignored.
- Register file reads: combinational. rdataN = 0 when rsN==0, otherwise regs[rsN].
- Read-during-write: a read of the register being written returns the old value until the edge, then the new value. No bypass.
- ALU opcodes (alu_ctr): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSA. Codes 11-15 are reserved and produce result 0.
- Decoder, fmt R: funct3 selects the operation.
  - 0: ADD, or SUB when funct7[5]=1.
  - 1: SLL. 2: SLT. 3: SLTU. 4: XOR.
  - 5: SRL, or SRA when funct7[5]=1.
  - 6: OR. 7: AND.
- Decoder, fmt I: same funct3 mapping as R, except funct3=0 is always ADD (no SUBI). funct7[5] is consulted only when funct3=5.
- Decoder, fmt U (8): PASSA (result = alu_a; core feeds immU on A).
- Decoder, all other fmt (IL, IE, S, B, J, JI, UP, 10-15): ADD, used for address, target and link computation.
- The decoder is purely combinational, with no latches for any fmt.
- ALU arithmetic: purely combinational, results modulo 2^32, overflow ignored.
  - Shift amount is alu_b[4:0]; SRA replicates alu_a[31].
  - SLT is a signed compare, SLTU unsigned; both give 32'd1 or 32'd0.
- zero is derived combinationally from alu_result.
- Reset mid-operation affects only the register array. ALU and decoder outputs follow their inputs regardless of resetn.

Test Plan:
- Reset/x0: hold resetn=0 for one edge, then read rs1=5 -> 0. Write rd=0, wdata=0xDEADBEEF, we=1 -> rdata1 for rs1=0 stays 0.
- Write/read and read-during-write: write rd=3, 0x12345678. Before the edge, rdata1(rs1=3) = old value 0; after the edge, 0x12345678 on both ports. Then we=0 with wdata changed -> value holds.
- R-type: fmt=0, funct3=0, funct7=0x20, a=5, b=7 -> alu_ctr=1, result 0xFFFFFFFE, zero=0. Same with funct7=0 -> 12.
- Shifts and compares:
  - fmt=1, funct3=5, funct7=0x20, a=0x80000000, b=4 -> 0xF8000000.
  - funct7=0 with the same operands -> 0x08000000.
  - fmt=0, funct3=2, a=0xFFFFFFFF, b=1 -> 1; funct3=3 with the same operands -> 0.
- Format overrides:
  - fmt=4 (S), funct3=2 -> ADD; a=0x100, b=0xFFFFFFFC -> 0xFC.
  - fmt=1, funct3=0, funct7=0x20 -> ADD, not SUB.
  - fmt=8, a=0xABCDE000 -> result 0xABCDE000.
- Zero flag and reset during write: fmt=0, funct3=4, a=b=0x55 -> result 0, zero=1. Assert resetn=0 together with we=1, rd=7 -> x7 reads 0 afterward.

Source files
------------

// File: rtl/rv32_regfile_alu.sv
// Integer execution slice for a multi-cycle RV32I core: 32x32 register file,
// ALU-control decoder and combinational ALU with zero flag.
module rv32_regfile_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata,
  input  logic            we,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [3:0]      fmt,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctr,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASSA = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    FMT_R  = 4'd0,
    FMT_I  = 4'd1,
    FMT_IL = 4'd2,
    FMT_IE = 4'd3,
    FMT_S  = 4'd4,
    FMT_B  = 4'd5,
    FMT_J  = 4'd6,
    FMT_JI = 4'd7,
    FMT_U  = 4'd8,
    FMT_UP = 4'd9
  } fmt_e;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [32];
  logic            wr_en_d;

  assign wr_en_d = we && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[rd] <= wdata;
    end
  end

  // x0 is forced at the read mux; no write-through bypass.
  assign rdata1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rdata2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  // ---------------------------------------------------------------------------
  // ALU-control decoder
  // ---------------------------------------------------------------------------
  alu_op_e op_d;
  alu_op_e funct_op_d;
  logic    alt_d;

  assign alt_d = funct7[5];

  // Shared funct3 mapping for R and I formats; ADD/SUB resolved below.
  always_comb begin
    funct_op_d = OP_ADD;
    case (funct3)
      3'd0:    funct_op_d = OP_ADD;
      3'd1:    funct_op_d = OP_SLL;
      3'd2:    funct_op_d = OP_SLT;
      3'd3:    funct_op_d = OP_SLTU;
      3'd4:    funct_op_d = OP_XOR;
      3'd5:    funct_op_d = alt_d ? OP_SRA : OP_SRL;
      3'd6:    funct_op_d = OP_OR;
      default: funct_op_d = OP_AND;
    endcase
  end

  always_comb begin
    op_d = OP_ADD;
    case (fmt)
      FMT_R: begin
        if (funct3 == 3'd0 && alt_d) op_d = OP_SUB;
        else                         op_d = funct_op_d;
      end
      FMT_I:   op_d = funct_op_d;
      FMT_U:   op_d = OP_PASSA;
      default: op_d = OP_ADD;
    endcase
  end

  assign alu_ctr = op_d;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [4:0] shamt_d;
  logic       lt_s_d;
  logic       lt_u_d;

  assign shamt_d = alu_b[4:0];
  assign lt_s_d  = $signed(alu_a) < $signed(alu_b);
  assign lt_u_d  = alu_a < alu_b;

  always_comb begin
    alu_result = '0;
    case (alu_ctr)
      OP_ADD:   alu_result = alu_a + alu_b;
      OP_SUB:   alu_result = alu_a - alu_b;
      OP_SLL:   alu_result = alu_a << shamt_d;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, lt_s_d};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, lt_u_d};
      OP_XOR:   alu_result = alu_a ^ alu_b;
      OP_SRL:   alu_result = alu_a >> shamt_d;
      OP_SRA:   alu_result = $unsigned($signed(alu_a) >>> shamt_d);
      OP_OR:    alu_result = alu_a | alu_b;
      OP_AND:   alu_result = alu_a & alu_b;
      OP_PASSA: alu_result = alu_a;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Only funct7[5] distinguishes operations in RV32I base.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

endmodule

// File: tb/tb_rv32_regfile_alu.sv
// Randomised + directed bench for rv32_regfile_alu with an expected-value
// scoreboard and a behavioural reference model of registers and ALU.
module tb_rv32_regfile_alu;

  logic        clk;
  logic        resetn;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata1, rdata2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  fmt;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_result;
  logic        zero;

  rv32_regfile_alu #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wdata(wdata), .we(we),
    .rdata1(rdata1), .rdata2(rdata2),
    .funct3(funct3), .funct7(funct7), .fmt(fmt),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctr(alu_ctr), .alu_result(alu_result), .zero(zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          tests;
  int          fails;
  logic [31:0] model_regs [32];

  localparam int K_RD1 = 0, K_RD2 = 1, K_CTR = 2, K_RES = 3, K_ZERO = 4;

  // Reference operation code from the decode table.
  function automatic int ref_op(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7);
    int ops_by_f3 [8];
    ops_by_f3 = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (f == 4'd8) return 10;
    if (f != 4'd0 && f != 4'd1) return 0;
    if (f3 == 3'd0) return (f == 4'd0 && f7[5]) ? 1 : 0;
    if (f3 == 3'd5) return f7[5] ? 7 : 6;
    return ops_by_f3[f3];
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      0:  return 32'(a + b);
      1:  return 32'(a - b);
      2:  return 32'(a * (64'd1 << sh));
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return 32'({32'd0, a} / (64'd1 << sh));
      7:  return 32'((sa - ((sa < 0) ? ((longint'(1) << sh) - 1) : 0)) / (longint'(1) << sh));
      8:  return a | b;
      9:  return a & b;
      10: return a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input string nm, input int kind, input logic [31:0] v);
    exp_q.push_back(v);
    kind_q.push_back(kind);
    name_q.push_back(nm);
  endtask

  // Push model expectations for the currently driven inputs, then advance one edge.
  task automatic step(input string nm);
    int          op;
    logic [31:0] res;
    op  = ref_op(fmt, funct3, funct7);
    res = ref_alu(op, alu_a, alu_b);
    push({nm, ".rdata1"}, K_RD1, (rs1 == 0) ? 32'd0 : model_regs[rs1]);
    push({nm, ".rdata2"}, K_RD2, (rs2 == 0) ? 32'd0 : model_regs[rs2]);
    push({nm, ".alu_ctr"}, K_CTR, 32'(op));
    push({nm, ".result"}, K_RES, res);
    push({nm, ".zero"}, K_ZERO, (res == 0) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (!resetn) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (we && rd != 5'd0) begin
      model_regs[rd] = wdata;
    end
    #1;
  endtask

  task automatic set_alu(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    fmt = f; funct3 = f3; funct7 = f7; alu_a = a; alu_b = b;
  endtask

  // monitor: combinational outputs are presented every cycle; compare on negedge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, act;
      int          k;
      string       nm;
      e  = exp_q.pop_front();
      k  = kind_q.pop_front();
      nm = name_q.pop_front();
      case (k)
        K_RD1:   act = rdata1;
        K_RD2:   act = rdata2;
        K_CTR:   act = {28'd0, alu_ctr};
        K_RES:   act = alu_result;
        default: act = {31'd0, zero};
      endcase
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    resetn = 1'b0; we = 1'b0; rs1 = 0; rs2 = 0; rd = 0; wdata = 0;
    set_alu(4'd0, 3'd0, 7'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // reset state and x0
    rs1 = 5; rs2 = 31;
    push("reset_x5", K_RD1, 32'd0);
    step("reset");
    rd = 0; wdata = 32'hDEADBEEF; we = 1; rs1 = 0;
    step("x0_write");
    we = 0;
    push("x0_read", K_RD1, 32'd0);
    step("x0_read");

    // write / read-during-write / hold
    rd = 3; wdata = 32'h12345678; we = 1; rs1 = 3; rs2 = 3;
    push("rdw_old", K_RD1, 32'd0);
    step("rdw");
    we = 0; wdata = 32'hCAFEF00D;
    push("new_p1", K_RD1, 32'h12345678);
    push("new_p2", K_RD2, 32'h12345678);
    step("after_write");
    push("hold", K_RD1, 32'h12345678);
    step("hold");

    // R-type SUB/ADD
    set_alu(4'd0, 3'd0, 7'h20, 32'd5, 32'd7);
    push("sub_ctr", K_CTR, 32'd1);
    push("sub_res", K_RES, 32'hFFFFFFFE);
    push("sub_zero", K_ZERO, 32'd0);
    step("sub");
    set_alu(4'd0, 3'd0, 7'h00, 32'd5, 32'd7);
    push("add_res", K_RES, 32'd12);
    step("add");

    // shifts and compares
    set_alu(4'd1, 3'd5, 7'h20, 32'h80000000, 32'd4);
    push("srai", K_RES, 32'hF8000000);
    step("srai");
    set_alu(4'd1, 3'd5, 7'h00, 32'h80000000, 32'd4);
    push("srli", K_RES, 32'h08000000);
    step("srli");
    set_alu(4'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1);
    push("slt", K_RES, 32'd1);
    step("slt");
    set_alu(4'd0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1);
    push("sltu", K_RES, 32'd0);
    step("sltu");

    // format overrides
    set_alu(4'd4, 3'd2, 7'h00, 32'h100, 32'hFFFFFFFC);
    push("store_ctr", K_CTR, 32'd0);
    push("store_res", K_RES, 32'hFC);
    step("store");
    set_alu(4'd1, 3'd0, 7'h20, 32'd5, 32'd7);
    push("addi_ctr", K_CTR, 32'd0);
    push("addi_res", K_RES, 32'd12);
    step("addi");
    set_alu(4'd8, 3'd0, 7'h00, 32'hABCDE000, 32'h1234);
    push("lui_ctr", K_CTR, 32'd10);
    push("lui_res", K_RES, 32'hABCDE000);
    step("lui");

    // zero flag, then reset racing a write
    set_alu(4'd0, 3'd4, 7'h00, 32'h55, 32'h55);
    push("xor_zero", K_ZERO, 32'd1);
    push("xor_res", K_RES, 32'd0);
    step("xor");
    rd = 7; wdata = 32'h77777777; we = 1; rs1 = 7;
    step("x7_write");
    we = 1; wdata = 32'h11111111; resetn = 0;
    push("alu_in_reset", K_RES, 32'd0);
    step("reset_write");
    resetn = 1; we = 0; rs2 = 3;
    push("x7_cleared", K_RD1, 32'd0);
    push("x3_cleared", K_RD2, 32'd0);
    step("post_reset");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      resetn = ($urandom_range(0, 63) != 0);
      we     = $urandom_range(0, 1);
      rd     = $urandom_range(0, 31);
      rs1    = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2    = $urandom_range(0, 31);
      wdata  = $urandom;
      set_alu(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
              ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
              ($urandom_range(0, 7) == 0) ? alu_a : $urandom);
      if ($urandom_range(0, 7) == 0) alu_b = alu_a;
      step("rand");
    end

    // bounded drain of the scoreboard
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
